// File: rtl/multicycle_main_control.sv
// Main control FSM for the multicycle RV32I datapath: sequences fetch/decode/execute/
// memory/writeback, handshakes with a variable-latency memory and traps bad opcodes.
module multicycle_main_control #(
  parameter logic [3:0] RESET_STATE = 4'd0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       adr_src,
  output logic       mem_write,
  output logic       ir_write,
  output logic       pc_write,
  output logic       reg_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [2:0] imm_src,
  output logic       illegal_instr,
  output logic [3:0] state_o
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_LUI      = 4'd8,
    S_JAL      = 4'd9,
    S_ALUWB    = 4'd10,
    S_BEQ      = 4'd11,
    S_TRAP     = 4'd12
  } state_t;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;

  state_t state_q, state_d;

  logic       mem_req_c, adr_src_c, mem_write_c, ir_write_c, pc_write_c, reg_write_c;
  logic       illegal_c;
  logic [1:0] result_src_c, alu_src_a_c, alu_src_b_c, alu_op_c;
  logic [2:0] imm_src_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= state_t'(RESET_STATE);
    else        state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    mem_req_c    = 1'b0;
    adr_src_c    = 1'b0;
    mem_write_c  = 1'b0;
    ir_write_c   = 1'b0;
    pc_write_c   = 1'b0;
    reg_write_c  = 1'b0;
    illegal_c    = 1'b0;
    result_src_c = 2'b00;
    alu_src_a_c  = 2'b00;
    alu_src_b_c  = 2'b00;
    alu_op_c     = 2'b00;
    unique case (state_q)
      S_FETCH: begin
        mem_req_c    = 1'b1;
        alu_src_b_c  = 2'b10;
        result_src_c = 2'b10;
        ir_write_c   = mem_ready;
        pc_write_c   = mem_ready;
        if (mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        // Precompute branch/jump target into ALUOut while the opcode is decoded.
        alu_src_a_c = 2'b01;
        alu_src_b_c = 2'b01;
        case (op)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_R:              state_d = S_EXECR;
          OP_I:              state_d = S_EXECI;
          OP_BEQ:            state_d = S_BEQ;
          OP_JAL:            state_d = S_JAL;
          OP_LUI:            state_d = S_LUI;
          default:           state_d = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        alu_src_a_c = 2'b10;
        alu_src_b_c = 2'b01;
        state_d     = (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        mem_req_c = 1'b1;
        adr_src_c = 1'b1;
        if (mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        result_src_c = 2'b01;
        reg_write_c  = 1'b1;
        state_d      = S_FETCH;
      end
      S_MEMWRITE: begin
        mem_req_c   = 1'b1;
        adr_src_c   = 1'b1;
        mem_write_c = 1'b1;
        if (mem_ready) state_d = S_FETCH;
      end
      S_EXECR: begin
        alu_src_a_c = 2'b10;
        alu_op_c    = 2'b10;
        state_d     = S_ALUWB;
      end
      S_EXECI: begin
        // addi immediate bit 30 must not be mistaken for the SUB selector.
        alu_src_a_c = 2'b10;
        alu_src_b_c = 2'b01;
        alu_op_c    = (funct3 == 3'b000) ? 2'b00 : 2'b10;
        state_d     = S_ALUWB;
      end
      S_LUI: begin
        alu_src_a_c = 2'b11;
        alu_src_b_c = 2'b01;
        alu_op_c    = 2'b11;
        state_d     = S_ALUWB;
      end
      S_JAL: begin
        alu_src_a_c = 2'b01;
        alu_src_b_c = 2'b10;
        pc_write_c  = 1'b1;
        state_d     = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write_c = 1'b1;
        state_d     = S_FETCH;
      end
      S_BEQ: begin
        alu_src_a_c = 2'b10;
        alu_op_c    = 2'b01;
        pc_write_c  = zero;
        state_d     = S_FETCH;
      end
      S_TRAP: begin
        illegal_c = 1'b1;
      end
      default: state_d = S_TRAP;
    endcase
  end

  always_comb begin
    imm_src_c = 3'b000;
    case (op)
      OP_STORE: imm_src_c = 3'b001;
      OP_BEQ:   imm_src_c = 3'b010;
      OP_JAL:   imm_src_c = 3'b011;
      OP_LUI:   imm_src_c = 3'b100;
      default:  imm_src_c = 3'b000;
    endcase
  end

  // Reset forces every output low immediately, independent of the clock.
  assign mem_req       = rst_n & mem_req_c;
  assign adr_src       = rst_n & adr_src_c;
  assign mem_write     = rst_n & mem_write_c;
  assign ir_write      = rst_n & ir_write_c;
  assign pc_write      = rst_n & pc_write_c;
  assign reg_write     = rst_n & reg_write_c;
  assign illegal_instr = rst_n & illegal_c;
  assign result_src    = rst_n ? result_src_c : 2'b00;
  assign alu_src_a     = rst_n ? alu_src_a_c  : 2'b00;
  assign alu_src_b     = rst_n ? alu_src_b_c  : 2'b00;
  assign alu_op        = rst_n ? alu_op_c     : 2'b00;
  assign imm_src       = rst_n ? imm_src_c    : 3'b000;
  assign state_o       = rst_n ? 4'(state_q)  : 4'd0;

endmodule

// File: tb/tb_multicycle_main_control.sv
// Scoreboard bench: stimulus queues the hand-written expected output vector for each
// cycle; a monitor on the falling edge pops and compares against the DUT.
module tb_multicycle_main_control;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] op = 7'd0;
  logic [2:0] funct3 = 3'd0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       mem_req, adr_src, mem_write, ir_write, pc_write, reg_write, illegal_instr;
  logic [1:0] result_src, alu_src_a, alu_src_b, alu_op;
  logic [2:0] imm_src;
  logic [3:0] state_o;

  multicycle_main_control dut (
    .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .zero(zero),
    .mem_ready(mem_ready), .mem_req(mem_req), .adr_src(adr_src),
    .mem_write(mem_write), .ir_write(ir_write), .pc_write(pc_write),
    .reg_write(reg_write), .result_src(result_src), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .imm_src(imm_src),
    .illegal_instr(illegal_instr), .state_o(state_o)
  );

  always #5 clk = ~clk;

  localparam logic [6:0] LW   = 7'b0000011;
  localparam logic [6:0] SW   = 7'b0100011;
  localparam logic [6:0] RT   = 7'b0110011;
  localparam logic [6:0] IT   = 7'b0010011;
  localparam logic [6:0] BEQ  = 7'b1100011;
  localparam logic [6:0] JAL  = 7'b1101111;
  localparam logic [6:0] LUI  = 7'b0110111;
  localparam logic [6:0] BAD  = 7'b1111111;

  logic [21:0] exp_q[$];
  string       name_q[$];
  int          total = 0;
  int          passed = 0;

  // {mem_req,adr_src,mem_write,ir_write,pc_write,reg_write,result_src,
  //  alu_src_a,alu_src_b,alu_op,imm_src,illegal_instr,state}
  function automatic logic [21:0] ev(input logic [3:0] st, input logic mreq, input logic adr,
                                     input logic mw, input logic irw, input logic pcw,
                                     input logic rw, input logic [1:0] rs, input logic [1:0] asa,
                                     input logic [1:0] asb, input logic [1:0] aop,
                                     input logic [2:0] imm, input logic ill);
    return {mreq, adr, mw, irw, pcw, rw, rs, asa, asb, aop, imm, ill, st};
  endfunction

  function automatic logic [21:0] x_fetch(input logic rdy, input logic [2:0] imm);
    return ev(4'd0, 1, 0, 0, rdy, rdy, 0, 2'b10, 2'b00, 2'b10, 2'b00, imm, 0);
  endfunction
  function automatic logic [21:0] x_decode(input logic [2:0] imm);
    return ev(4'd1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b00, imm, 0);
  endfunction
  function automatic logic [21:0] x_memadr(input logic [2:0] imm);
    return ev(4'd2, 0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, imm, 0);
  endfunction
  function automatic logic [21:0] x_memread();
    return ev(4'd3, 1, 1, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 0);
  endfunction
  function automatic logic [21:0] x_memwb();
    return ev(4'd4, 0, 0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, 2'b00, 3'b000, 0);
  endfunction
  function automatic logic [21:0] x_memwrite();
    return ev(4'd5, 1, 1, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b001, 0);
  endfunction
  function automatic logic [21:0] x_execi(input logic [1:0] aop);
    return ev(4'd7, 0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, aop, 3'b000, 0);
  endfunction
  function automatic logic [21:0] x_aluwb(input logic [2:0] imm);
    return ev(4'd10, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, imm, 0);
  endfunction
  function automatic logic [21:0] x_beq(input logic z);
    return ev(4'd11, 0, 0, 0, 0, z, 0, 2'b00, 2'b10, 2'b00, 2'b01, 3'b010, 0);
  endfunction

  task automatic cyc(input string n, input logic r, input logic [6:0] o, input logic [2:0] f,
                     input logic z, input logic rdy, input logic [21:0] e);
    @(posedge clk);
    #1;
    rst_n = r; op = o; funct3 = f; zero = z; mem_ready = rdy;
    exp_q.push_back(e);
    name_q.push_back(n);
  endtask

  initial begin : monitor
    logic [21:0] act, e;
    string n;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n = name_q.pop_front();
        act = {mem_req, adr_src, mem_write, ir_write, pc_write, reg_write, result_src,
               alu_src_a, alu_src_b, alu_op, imm_src, illegal_instr, state_o};
        total++;
        if (act !== e) $display("FAIL %s: got %h expected %h", n, act, e);
        else begin
          passed++;
          $display("ok   %s: %h", n, act);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    // Reset held with FETCH-like inputs: all outputs must stay 0.
    cyc("rst_a", 0, LW, 3'd0, 1, 1, 22'd0);
    cyc("rst_b", 0, LW, 3'd0, 1, 1, 22'd0);
    // lw, no wait states: 0,1,2,3,4
    cyc("lw_fetch",  1, LW, 3'd0, 0, 1, x_fetch(1, 3'b000));
    cyc("lw_decode", 1, LW, 3'd0, 0, 1, x_decode(3'b000));
    cyc("lw_memadr", 1, LW, 3'd0, 0, 1, x_memadr(3'b000));
    cyc("lw_memrd",  1, LW, 3'd0, 0, 1, x_memread());
    cyc("lw_memwb",  1, LW, 3'd0, 0, 1, x_memwb());
    // add: 0,1,6,10
    cyc("add_fetch",  1, RT, 3'd0, 0, 1, x_fetch(1, 3'b000));
    cyc("add_decode", 1, RT, 3'd0, 0, 1, x_decode(3'b000));
    cyc("add_execr",  1, RT, 3'd0, 0, 1,
        ev(4'd6, 0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b10, 3'b000, 0));
    cyc("add_aluwb",  1, RT, 3'd0, 0, 1, x_aluwb(3'b000));
    // addi (funct3=000) keeps alu_op=00; xori (funct3=100) uses 10
    cyc("addi_fetch",  1, IT, 3'd0, 0, 1, x_fetch(1, 3'b000));
    cyc("addi_decode", 1, IT, 3'd0, 0, 1, x_decode(3'b000));
    cyc("addi_execi",  1, IT, 3'd0, 0, 1, x_execi(2'b00));
    cyc("addi_aluwb",  1, IT, 3'd0, 0, 1, x_aluwb(3'b000));
    cyc("xori_fetch",  1, IT, 3'd4, 0, 1, x_fetch(1, 3'b000));
    cyc("xori_decode", 1, IT, 3'd4, 0, 1, x_decode(3'b000));
    cyc("xori_execi",  1, IT, 3'd4, 0, 1, x_execi(2'b10));
    cyc("xori_aluwb",  1, IT, 3'd4, 0, 1, x_aluwb(3'b000));
    // lui: U immediate, alu_src_a=11, alu_op=11
    cyc("lui_fetch",  1, LUI, 3'd0, 0, 1, x_fetch(1, 3'b100));
    cyc("lui_decode", 1, LUI, 3'd0, 0, 1, x_decode(3'b100));
    cyc("lui_exec",   1, LUI, 3'd0, 0, 1,
        ev(4'd8, 0, 0, 0, 0, 0, 0, 2'b00, 2'b11, 2'b01, 2'b11, 3'b100, 0));
    cyc("lui_aluwb",  1, LUI, 3'd0, 0, 1, x_aluwb(3'b100));
    // jal: PC <- target, OldPC+4 written back
    cyc("jal_fetch",  1, JAL, 3'd0, 0, 1, x_fetch(1, 3'b011));
    cyc("jal_decode", 1, JAL, 3'd0, 0, 1, x_decode(3'b011));
    cyc("jal_exec",   1, JAL, 3'd0, 0, 1,
        ev(4'd9, 0, 0, 0, 0, 1, 0, 2'b00, 2'b01, 2'b10, 2'b00, 3'b011, 0));
    cyc("jal_aluwb",  1, JAL, 3'd0, 0, 1, x_aluwb(3'b011));
    // beq taken then not taken, 3 cycles each
    cyc("beqt_fetch",  1, BEQ, 3'd0, 1, 1, x_fetch(1, 3'b010));
    cyc("beqt_decode", 1, BEQ, 3'd0, 1, 1, x_decode(3'b010));
    cyc("beqt_beq",    1, BEQ, 3'd0, 1, 1, x_beq(1));
    cyc("beqn_fetch",  1, BEQ, 3'd0, 0, 1, x_fetch(1, 3'b010));
    cyc("beqn_decode", 1, BEQ, 3'd0, 0, 1, x_decode(3'b010));
    cyc("beqn_beq",    1, BEQ, 3'd0, 0, 1, x_beq(0));
    // sw: 2 wait cycles in FETCH, 3 wait cycles in MEMWRITE
    cyc("sw_fetch_w0", 1, SW, 3'd0, 0, 0, x_fetch(0, 3'b001));
    cyc("sw_fetch_w1", 1, SW, 3'd0, 0, 0, x_fetch(0, 3'b001));
    cyc("sw_fetch_rdy", 1, SW, 3'd0, 0, 1, x_fetch(1, 3'b001));
    cyc("sw_decode",   1, SW, 3'd0, 0, 1, x_decode(3'b001));
    cyc("sw_memadr",   1, SW, 3'd0, 0, 1, x_memadr(3'b001));
    for (int i = 0; i < 3; i++)
      cyc($sformatf("sw_memwr_w%0d", i), 1, SW, 3'd0, 0, 0, x_memwrite());
    cyc("sw_memwr_rdy", 1, SW, 3'd0, 0, 1, x_memwrite());
    // lw interrupted by reset while waiting in MEMREAD
    cyc("lwr_fetch",  1, LW, 3'd0, 0, 1, x_fetch(1, 3'b000));
    cyc("lwr_decode", 1, LW, 3'd0, 0, 1, x_decode(3'b000));
    cyc("lwr_memadr", 1, LW, 3'd0, 0, 0, x_memadr(3'b000));
    cyc("lwr_memrd",  1, LW, 3'd0, 0, 0, x_memread());
    cyc("lwr_rst_a",  0, LW, 3'd0, 0, 1, 22'd0);
    cyc("lwr_rst_b",  0, LW, 3'd0, 0, 1, 22'd0);
    cyc("lwr_release", 1, LW, 3'd0, 0, 0, x_fetch(0, 3'b000));
    // unsupported opcode traps and stays trapped
    cyc("bad_fetch",  1, BAD, 3'd0, 0, 1, x_fetch(1, 3'b000));
    cyc("bad_decode", 1, BAD, 3'd0, 0, 1, x_decode(3'b000));
    for (int i = 0; i < 20; i++)
      cyc($sformatf("trap_%0d", i), 1, BAD, 3'd0, i[0], i[1],
          ev(4'd12, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 1));

    repeat (3) @(negedge clk);
    if (exp_q.size() != 0) begin
      total++;
      $display("FAIL drain: got %0d pending expectations, required 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/multicycle_main_control.md
Name: multicycle_main_control

Overview:
- Main control FSM for the multicycle RV32I datapath; it produces the 2-bit ALUOp consumed by the ALU control decoder, plus all datapath mux and enable strobes.
- Sequences each instruction as fetch, decode, then opcode-specific execute, memory and writeback states.
- Handshakes with a variable-latency unified instruction/data memory.
- Traps unsupported opcodes into a sticky error state.

Parameters:
- RESET_STATE, 4'd0, state code loaded on reset (FETCH); kept for FPGA init-value tests.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- op  input  7  instruction[6:0] from IR
- funct3  input  3  instruction[14:12] from IR
- zero  input  1  ALU zero flag
- mem_ready  input  1  memory completed the access this cycle
- mem_req  output  1  memory access request
- adr_src  output  1  0 = PC, 1 = ALUOut as memory address
- mem_write  output  1  store strobe
- ir_write  output  1  IR/OldPC load enable
- pc_write  output  1  PC load enable
- reg_write  output  1  register file write enable
- result_src  output  2  00 ALUOut, 01 read data, 10 ALUResult
- alu_src_a  output  2  00 PC, 01 OldPC, 10 rs1 reg A, 11 zero
- alu_src_b  output  2  00 reg B, 01 immediate, 10 constant 4
- alu_op  output  2  00 add, 01 sub, 10 funct decode, 11 default/add (LUI)
- imm_src  output  3  000 I, 001 S, 010 B, 011 J, 100 U
- illegal_instr  output  1  sticky trap flag
- state_o  output  4  current state (debug)

Behaviour:
- Single state register with async clear to FETCH.
- While rst_n=0, every output is 0. FETCH is active on the first clk edge after release.
- Outputs are Moore decodes of state, except as noted below. Fields not listed are 0.
- imm_src is combinational from op:
  - lw / ALU-imm: I
  - sw: S
  - beq: B
  - jal: J
  - lui: U
  - other: 000
- States, encodings, outputs and transitions:
  - FETCH(0): mem_req=1, adr_src=0, alu_src_a=00, alu_src_b=10, alu_op=00, result_src=10. ir_write and pc_write are asserted only when mem_ready=1. Stays in FETCH while mem_ready=0, with no IR or PC change. Goes to DECODE when mem_ready=1.
  - DECODE(1): alu_src_a=01, alu_src_b=01, alu_op=00 (branch/jump target into ALUOut). Next state by op:
    - 0000011 / 0100011 -> MEMADR
    - 0110011 -> EXECR
    - 0010011 -> EXECI
    - 1100011 -> BEQ
    - 1101111 -> JAL
    - 0110111 -> LUI
    - else -> TRAP
  - MEMADR(2): alu_src_a=10, alu_src_b=01, alu_op=00. Goes to MEMREAD if op=0000011, else MEMWRITE.
  - MEMREAD(3): mem_req=1, adr_src=1. Waits for mem_ready, then goes to MEMWB.
  - MEMWB(4): result_src=01, reg_write=1, then FETCH.
  - MEMWRITE(5): mem_req=1, adr_src=1, mem_write=1, all held until the mem_ready cycle inclusive, then FETCH.
  - EXECR(6): alu_src_a=10, alu_src_b=00, alu_op=10, then ALUWB.
  - EXECI(7): alu_src_a=10, alu_src_b=01. alu_op=00 when funct3=000 (addi: immediate bits must not select SUB), else 10. Then ALUWB.
  - LUI(8): alu_src_a=11, alu_src_b=01, alu_op=11, then ALUWB.
  - JAL(9): alu_src_a=01, alu_src_b=10, alu_op=00, result_src=00, pc_write=1 (PC <- ALUOut target, ALU computes OldPC+4), then ALUWB.
  - ALUWB(10): result_src=00, reg_write=1, then FETCH.
  - BEQ(11): alu_src_a=10, alu_src_b=00, alu_op=01, result_src=00. pc_write = zero (combinational). Then FETCH.
  - TRAP(12): illegal_instr=1; all strobes and mem_req are 0. Exits only on reset.
  - Codes 13-15: go to TRAP.
- Cycle counts with mem_ready=1:
  - lw: 5
  - sw: 4
  - R-type / I-type / lui / jal: 4
  - beq: 3
- Each memory wait cycle adds 1.
- mem_ready is ignored outside FETCH, MEMREAD and MEMWRITE.
- Exactly one of reg_write and mem_write may be high in any cycle; never both.
- Reset asserted mid-instruction: outputs drop to 0 immediately (asynchronously). No partial writeback completes.

Test Plan:
- lw (op=0000011), mem_ready=1: state_o sequence 0,1,2,3,4,0; reg_write=1 with result_src=01 only in state 4.
- add (op=0110011): states 0,1,6,10,0; alu_op=10 in state 6.
- addi with funct3=000: alu_op=00 in EXECI. xori with funct3=100: alu_op=10.
- beq with zero=1: pc_write=1 in state 11. Repeat with zero=0: pc_write=0. Returns to FETCH after 3 cycles.
- sw with mem_ready low for 3 cycles in MEMWRITE: mem_write=1 for 4 consecutive cycles, then FETCH. Hold mem_ready low for 2 cycles in FETCH: ir_write and pc_write stay 0 until the ready cycle.
- op=1111111: DECODE -> TRAP; illegal_instr=1 stays set for 20 cycles. Assert rst_n=0 mid-MEMREAD: all outputs 0 the same cycle; after release state_o=0.
